// File: rtl/fft32_out_serializer.sv
// Output serializer for the 32-point FFT: captures one 32-lane complex frame
// and streams it one sample per beat over valid/ready, flagging dropped frames.
module fft32_out_serializer #(
  parameter int unsigned N      = 8,
  parameter int unsigned Q      = 4,
  parameter int unsigned BITREV = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [32*N-1:0] in_r,
  input  logic [32*N-1:0] in_i,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [N-1:0]    out_r,
  output logic [N-1:0]    out_i,
  output logic [4:0]      out_idx,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            overrun
);

  localparam int unsigned LANES = 32;
  localparam int unsigned BUF_W = LANES * N;

  // Q only documents the fixed-point format; reject nonsensical settings early.
  if (Q >= N) begin : g_q_check
    $error("fft32_out_serializer: Q must be smaller than N");
  end

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [4:0]       cnt;
  logic [4:0]       cnt_next;
  logic             load;
  logic             overrun_next;
  logic [BUF_W-1:0] buf_r;
  logic [BUF_W-1:0] buf_i;
  logic [4:0]       cnt_rev;

  // Next-state logic; the butterflies cannot stall, so a strobe while streaming is dropped.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    load         = 1'b0;
    overrun_next = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load       = 1'b1;
          cnt_next   = 5'd0;
          state_next = STREAM;
        end
      end
      STREAM: begin
        overrun_next = in_valid;
        if (out_ready) begin
          cnt_next = cnt + 5'd1;
          if (cnt == 5'd31) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      overrun <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      overrun <= overrun_next;
    end
  end

  // Capture buffer: all 64 lane registers load together on an accepted frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_r <= '0;
      buf_i <= '0;
    end else if (load) begin
      buf_r <= in_r;
      buf_i <= in_i;
    end
  end

  assign cnt_rev   = {cnt[0], cnt[1], cnt[2], cnt[3], cnt[4]};
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == STREAM);
  assign out_last  = (state == STREAM) && (cnt == 5'd31);
  assign out_idx   = (BITREV != 0) ? cnt_rev : cnt;
  assign out_r     = buf_r[32'(out_idx) * N +: N];
  assign out_i     = buf_i[32'(out_idx) * N +: N];

endmodule

// File: tb/tb_fft32_out_serializer.sv
// Directed bench for fft32_out_serializer: natural and bit-reversed instances
// share stimulus; each scenario task checks its own expectations inline.
module tb_fft32_out_serializer;

  localparam int unsigned N = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [32*N-1:0] in_r;
  logic [32*N-1:0] in_i;
  logic           in_valid;
  logic           out_ready;

  logic           rdy0, v0, l0, ov0;
  logic [N-1:0]   r0, i0;
  logic [4:0]     x0;
  logic           rdy1, v1, l1, ov1;
  logic [N-1:0]   r1, i1;
  logic [4:0]     x1;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  fft32_out_serializer #(.N(N), .Q(4), .BITREV(0)) dut0 (
    .clk(clk), .rst(rst), .in_r(in_r), .in_i(in_i), .in_valid(in_valid),
    .in_ready(rdy0), .out_r(r0), .out_i(i0), .out_idx(x0), .out_valid(v0),
    .out_ready(out_ready), .out_last(l0), .overrun(ov0)
  );

  fft32_out_serializer #(.N(N), .Q(4), .BITREV(1)) dut1 (
    .clk(clk), .rst(rst), .in_r(in_r), .in_i(in_i), .in_valid(in_valid),
    .in_ready(rdy1), .out_r(r1), .out_i(i1), .out_idx(x1), .out_valid(v1),
    .out_ready(out_ready), .out_last(l1), .overrun(ov1)
  );

  // Frame patterns: 0 = ramp (k, -k), 1 = extremes, 2 = alternate frame.
  function automatic logic [7:0] exp_r(input int mode, input int k);
    case (mode)
      0:       exp_r = 8'(k);
      1:       exp_r = (k % 2 == 0) ? 8'h7F : 8'h80;
      default: exp_r = 8'(k * 7 + 3);
    endcase
  endfunction

  function automatic logic [7:0] exp_i(input int mode, input int k);
    case (mode)
      0:       exp_i = 8'(0 - k);
      1:       exp_i = (k % 2 == 0) ? 8'h80 : 8'h7F;
      default: exp_i = 8'(8'hA5 ^ 8'(k));
    endcase
  endfunction

  function automatic logic [4:0] rev5(input int j);
    logic [4:0] v;
    logic [4:0] r;
    v = 5'(j);
    for (int b = 0; b < 5; b++) r[4-b] = v[b];
    return r;
  endfunction

  task automatic load_frame(input int mode);
    for (int k = 0; k < 32; k++) begin
      in_r[k*N +: N] = exp_r(mode, k);
      in_i[k*N +: N] = exp_i(mode, k);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_r = '1;
    in_i = '1;
    #12;
    total_cnt++;
    if ({rdy0, v0, l0, r0, i0, x0, ov0} !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 5'd0, 1'b0}) begin
      $display("FAIL reset_dut0: got rdy=%b v=%b last=%b r=%h i=%h idx=%0d ov=%b, want 1 0 0 00 00 0 0",
               rdy0, v0, l0, r0, i0, x0, ov0);
    end else pass_cnt++;
    total_cnt++;
    if ({rdy1, v1, l1, r1, i1, x1, ov1} !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 5'd0, 1'b0}) begin
      $display("FAIL reset_dut1: got rdy=%b v=%b last=%b r=%h i=%h idx=%0d ov=%b, want 1 0 0 00 00 0 0",
               rdy1, v1, l1, r1, i1, x1, ov1);
    end else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if ({rdy0, v0} !== 2'b10) begin
      $display("FAIL idle_hold: got rdy=%b v=%b, want rdy=1 v=0", rdy0, v0);
    end else pass_cnt++;
  endtask

  task automatic test_natural_and_bitrev();
    logic [4:0] seen_x [0:31];
    logic [7:0] seen_r [0:31];
    logic [4:0] want_x [0:3];
    want_x[0] = 5'd0; want_x[1] = 5'd16; want_x[2] = 5'd8; want_x[3] = 5'd24;
    out_ready = 1'b1;
    load_frame(0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int j = 0; j < 32; j++) begin
      if (j != 0) @(negedge clk);
      seen_x[j] = x1;
      seen_r[j] = r1;
      total_cnt++;
      if ({v0, x0, r0, i0, l0, rdy0} !== {1'b1, 5'(j), exp_r(0, j), exp_i(0, j), (j == 31), 1'b0}) begin
        $display("FAIL nat_beat%0d: got v=%b idx=%0d r=%h i=%h last=%b rdy=%b, want v=1 idx=%0d r=%h i=%h last=%b rdy=0",
                 j, v0, x0, r0, i0, l0, rdy0, j, exp_r(0, j), exp_i(0, j), (j == 31));
      end else pass_cnt++;
      total_cnt++;
      if ({v1, x1, r1, i1, l1} !== {1'b1, rev5(j), exp_r(0, int'(rev5(j))), exp_i(0, int'(rev5(j))), (j == 31)}) begin
        $display("FAIL rev_beat%0d: got v=%b idx=%0d r=%h i=%h last=%b, want idx=%0d last=%b",
                 j, v1, x1, r1, i1, l1, rev5(j), (j == 31));
      end else pass_cnt++;
    end
    for (int j = 0; j < 4; j++) begin
      total_cnt++;
      if ({seen_x[j], seen_r[j]} !== {want_x[j], 3'b000, want_x[j]}) begin
        $display("FAIL rev_order%0d: got idx=%0d r=%h, want idx=%0d r=%h",
                 j, seen_x[j], seen_r[j], want_x[j], {3'b000, want_x[j]});
      end else pass_cnt++;
    end
    total_cnt++;
    if (seen_x[31] !== 5'd31) begin
      $display("FAIL rev_last_idx: got %0d, want 31", seen_x[31]);
    end else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({rdy0, v0, l0, rdy1, v1} !== 5'b10010) begin
      $display("FAIL nat_ready_after33: got rdy0=%b v0=%b last0=%b rdy1=%b v1=%b, want 1 0 0 1 0",
               rdy0, v0, l0, rdy1, v1);
    end else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int   e;
    int   cyc;
    int   acc;
    logic prev;
    logic [3:0] pat;
    pat = 4'b1001;
    e = 0;
    acc = 0;
    prev = 1'b0;
    out_ready = 1'b0;
    load_frame(2);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (cyc = 0; cyc < 400; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (prev) begin
        e++;
        acc++;
      end
      if (e == 32) break;
      total_cnt++;
      if ({v0, x0, r0, i0, l0} !== {1'b1, 5'(e), exp_r(2, e), exp_i(2, e), (e == 31)}) begin
        $display("FAIL bp_beat%0d_cyc%0d: got v=%b idx=%0d r=%h i=%h last=%b, want idx=%0d r=%h i=%h last=%b",
                 e, cyc, v0, x0, r0, i0, l0, e, exp_r(2, e), exp_i(2, e), (e == 31));
      end else pass_cnt++;
      total_cnt++;
      if ({v1, x1, r1, l1} !== {1'b1, rev5(e), exp_r(2, int'(rev5(e))), (e == 31)}) begin
        $display("FAIL bp_rev_beat%0d: got v=%b idx=%0d r=%h last=%b, want idx=%0d",
                 e, v1, x1, r1, l1, rev5(e));
      end else pass_cnt++;
      out_ready = (cyc < 4) ? pat[3-cyc] : 1'($urandom_range(0, 1));
      prev = out_ready;
    end
    total_cnt++;
    if (acc != 32 || v0 !== 1'b0 || rdy0 !== 1'b1) begin
      $display("FAIL bp_complete: got accepted=%0d v=%b rdy=%b after %0d cycles, want 32 0 1",
               acc, v0, rdy0, cyc);
    end else pass_cnt++;
    out_ready = 1'b1;
  endtask

  task automatic test_overrun();
    out_ready = 1'b1;
    load_frame(0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int j = 0; j < 32; j++) begin
      if (j != 0) @(negedge clk);
      total_cnt++;
      if ({v0, x0, r0, i0, ov0, ov1} !== {1'b1, 5'(j), exp_r(0, j), exp_i(0, j), (j == 10), (j == 10)}) begin
        $display("FAIL ovr_beat%0d: got v=%b idx=%0d r=%h i=%h ov0=%b ov1=%b, want idx=%0d r=%h i=%h ov=%b",
                 j, v0, x0, r0, i0, ov0, ov1, j, exp_r(0, j), exp_i(0, j), (j == 10));
      end else pass_cnt++;
      // Dropped frame carries different data so any corruption would show up.
      if (j == 9) begin
        load_frame(2);
        in_valid = 1'b1;
      end else begin
        in_valid = (j == 31);
      end
    end
    @(negedge clk);
    total_cnt++;
    if ({ov0, rdy0, v0} !== 3'b110) begin
      $display("FAIL ovr_last_edge: got ov=%b rdy=%b v=%b, want 1 1 0", ov0, rdy0, v0);
    end else pass_cnt++;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int j = 0; j < 32; j++) begin
      if (j != 0) @(negedge clk);
      total_cnt++;
      if ({v0, x0, r0, i0, l0, ov0} !== {1'b1, 5'(j), exp_r(2, j), exp_i(2, j), (j == 31), 1'b0}) begin
        $display("FAIL ovr_next_beat%0d: got v=%b idx=%0d r=%h i=%h last=%b ov=%b, want idx=%0d r=%h i=%h",
                 j, v0, x0, r0, i0, l0, ov0, j, exp_r(2, j), exp_i(2, j));
      end else pass_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    load_frame(0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int j = 1; j <= 12; j++) @(negedge clk);
    total_cnt++;
    if ({v0, x0, r0} !== {1'b1, 5'd12, 8'd12}) begin
      $display("FAIL rstmid_pre: got v=%b idx=%0d r=%h, want 1 12 0c", v0, x0, r0);
    end else pass_cnt++;
    #2;
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({v0, r0, i0, rdy0, l0, x0} !== {1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 5'd0}) begin
      $display("FAIL rstmid_async0: got v=%b r=%h i=%h rdy=%b last=%b idx=%0d, want 0 00 00 1 0 0",
               v0, r0, i0, rdy0, l0, x0);
    end else pass_cnt++;
    total_cnt++;
    if ({v1, r1, i1, rdy1, l1} !== {1'b0, 8'h00, 8'h00, 1'b1, 1'b0}) begin
      $display("FAIL rstmid_async1: got v=%b r=%h i=%h rdy=%b last=%b, want 0 00 00 1 0",
               v1, r1, i1, rdy1, l1);
    end else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    load_frame(2);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int j = 0; j < 32; j++) begin
      if (j != 0) @(negedge clk);
      total_cnt++;
      if ({v0, x0, r0, i0, l0} !== {1'b1, 5'(j), exp_r(2, j), exp_i(2, j), (j == 31)}) begin
        $display("FAIL rstmid_beat%0d: got v=%b idx=%0d r=%h i=%h last=%b, want idx=%0d r=%h i=%h",
                 j, v0, x0, r0, i0, l0, j, exp_r(2, j), exp_i(2, j));
      end else pass_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic test_extremes();
    out_ready = 1'b1;
    load_frame(1);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int j = 0; j < 32; j++) begin
      if (j != 0) @(negedge clk);
      total_cnt++;
      if ({r0, i0} !== ((j % 2 == 0) ? 16'h7F80 : 16'h807F)) begin
        $display("FAIL ext_beat%0d: got r=%h i=%h, want %s", j, r0, i0,
                 (j % 2 == 0) ? "7f 80" : "80 7f");
      end else pass_cnt++;
      total_cnt++;
      if ({r1, i1} !== ((rev5(j) % 2 == 0) ? 16'h7F80 : 16'h807F)) begin
        $display("FAIL ext_rev_beat%0d: got idx=%0d r=%h i=%h", j, x1, r1, i1);
      end else pass_cnt++;
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_natural_and_bitrev();
    test_backpressure();
    test_overrun();
    test_reset_mid();
    test_extremes();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fft32_out_serializer.md
Name: fft32_out_serializer

Overview:
- Sits directly downstream of the final 32-lane butterfly stage of the 32-point DIT FFT.
- Captures one parallel frame of 32 complex results in a single cycle, when strobed by pipeline control.
- Streams the frame out one complex sample per beat over a valid/ready interface, with index and last-beat tags.
- Flags any frame that arrives while the previous frame is still streaming, because the butterfly stages cannot accept backpressure.

Parameters:
- N, 8: bit width of each real/imag sample (two's complement, matches butterfly datapath).
- Q, 4: fractional bits. Carried for consistency only; no arithmetic is performed.
- BITREV, 0: 0 = emit lanes in natural order 0..31; 1 = emit lane bitrev5(beat), i.e. lane 0,16,8,24,...

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- in_r  input  32*N  packed real parts; lane k at bits [k*N +: N] (lane k = butterfly outk_r).
- in_i  input  32*N  packed imag parts, same packing as in_r.
- in_valid  input  1  frame strobe, aligned with the butterfly stage's registered outputs.
- in_ready  output  1  high when a frame can be captured.
- out_r  output  N  real part of the current beat.
- out_i  output  N  imag part of the current beat.
- out_idx  output  5  lane index of the current beat.
- out_valid  output  1  beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_last  output  1  high on beat 31 of a frame.
- overrun  output  1  one-cycle pulse: a frame was dropped.

Behaviour:
- States: IDLE, STREAM. Reset (rst=0, asynchronous) forces:
  - state=IDLE, beat counter=0, capture buffer=0, overrun=0.
  - Outputs during reset: in_ready=1, out_valid=0, out_last=0, out_r=out_i=0, out_idx=0.
- in_ready = (state==IDLE). It is combinational from the state register, with no dependency on in_valid or out_ready.
- IDLE:
  - in_valid=1 at a rising edge → all 64 lane registers load, counter=0, state→STREAM.
  - in_valid=0 → remain in IDLE.
- STREAM:
  - out_valid=1.
  - out_idx = counter (BITREV=0) or bitrev5(counter) (BITREV=1).
  - out_r/out_i = buffer lane out_idx; out_last = (counter==31).
  - Each edge with out_ready=1 is an accepted beat; counter increments.
  - An accepted beat with counter==31 → counter=0, state→IDLE.
  - out_ready=0 → counter, out_r, out_i, out_idx and out_last all hold stable. Valid is never withdrawn.
- Latency and throughput:
  - Frame captured at edge t0 → beat 0 presented in the cycle after t0.
  - With out_ready tied high, beats are accepted at edges t1..t32 and in_ready=1 again after t32.
  - Next capture is possible at t33, so the minimum frame period is 33 cycles.
- Overrun:
  - in_valid=1 while state==STREAM → that frame is discarded.
  - The buffer and stream are unaffected; overrun=1 for the following cycle only, and re-pulses for each dropped strobe.
  - On the edge that completes beat 31, in_ready is still 0, so a strobe on that edge is an overrun.
- Data is passed bit-exact; there is no rounding or scaling, and Q is unused.
- Reset mid-stream aborts the frame immediately: no out_last is issued and the buffer clears to 0. After release the block is in IDLE, ready for a new frame.

Test Plan:
- Basic frame, natural order: lane k = (r=k, i=-k), in_valid 1 cycle, out_ready=1, BITREV=0.
  - Required: 32 beats on consecutive cycles starting the cycle after capture.
  - Required: beat j gives out_idx=j, out_r=j, out_i=-j; out_last only at j=31; in_ready=1 again 33 cycles after capture edge.
- Bit-reversed order: same frame, BITREV=1.
  - Required: beats 0..3 show out_idx 0,16,8,24 with out_r 0,16,8,24; beat 31 out_idx=31; out_last only on beat 31.
- Backpressure: out_ready toggles 1,0,0,1,... (random ~50%).
  - Required: data/idx/last held stable through every stall; exactly 32 accepted beats in order; no duplicates or skips.
- Overrun: second in_valid 10 cycles after the first capture.
  - Required: overrun=1 for one cycle; first frame streams intact.
  - Required: a strobe on the beat-31 completion edge also overruns; a strobe 1 cycle later is captured.
- Reset mid-operation: assert rst=0 after beat 12 of a frame.
  - Required: out_valid=0 and out_r=out_i=0 immediately (asynchronous), in_ready=1.
  - Required: after release, a new frame streams from beat 0 with correct values.
- Extremes (N=8): lanes hold r=0x7F/0x80 alternating, i inverted.
  - Required: values emitted bit-exact, sign preserved.
